// File: rtl/pc_stack.sv
// -----------------------------------------------------------------------------
// pc_stack
// Program-counter register with an integrated return-address stack. Presents
// the current PC, PC+1 and the top-of-stack return address to the downstream
// next-PC select mux, and registers the mux output each enabled cycle. call/ret
// push and pop return addresses in step with the PC update.
//
// Parameters:
//   AW     address/PC width
//   DEPTH  return-stack entries (power of two)
//   PW     pointer width, log2(DEPTH)
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   pc_en     in   advance enable; PC and stack change only when high
//   pc_next   in   next PC from the select mux
//   call      in   push return address (qualified by pc_en)
//   ret       in   pop return address (qualified by pc_en)
//   pc        out  current PC (registered)
//   pc_inc    out  pc + 1, wrapping
//   ret_addr  out  top-of-stack entry, 0 when empty
//   full      out  stack holds DEPTH entries
//   empty     out  stack holds no entries
//   err       out  sticky misuse flag
//
// Build option:
//   PC_STACK_ERR_EN  when defined, err sets on a dropped push (full) or a
//                    dropped pop (empty) and holds until reset. When not
//                    defined, err is tied low and no error logic exists.
// -----------------------------------------------------------------------------
module pc_stack #(
   parameter int AW    = 13,
   parameter int DEPTH = 8,
   parameter int PW    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pc_en,
   input  logic [AW-1:0] pc_next,
   input  logic          call,
   input  logic          ret,
   output logic [AW-1:0] pc,
   output logic [AW-1:0] pc_inc,
   output logic [AW-1:0] ret_addr,
   output logic          full,
   output logic          empty,
   output logic          err
);

   logic [AW-1:0] pc_r;
   logic [AW-1:0] stack_r [DEPTH];
   logic [PW-1:0] sp_r;
   logic [PW:0]   cnt_r;

   logic [AW-1:0] pc_inc_s;
   logic [PW-1:0] top_idx_s;
   logic          full_s;
   logic          empty_s;
   logic          push_s;
   logic          pop_s;
   logic          repl_s;

   // Status and mux-facing values derived from the registered state
   always_comb begin
      pc_inc_s  = pc_r + AW'(1);
      // sp-1 wraps to DEPTH-1 when sp is 0 and the stack is full
      top_idx_s = sp_r - PW'(1);
      full_s    = (cnt_r == (PW+1)'(DEPTH));
      empty_s   = (cnt_r == (PW+1)'(0));
   end

   // Decode the enabled {call, ret} command into a single stack action
   always_comb begin
      push_s = 1'b0;
      pop_s  = 1'b0;
      repl_s = 1'b0;
      if (pc_en) begin
         case ({call, ret})
            2'b10: begin
               if (full_s) begin
                  push_s = 1'b0;
               end else begin
                  push_s = 1'b1;
               end
            end
            2'b01: begin
               if (empty_s) begin
                  pop_s = 1'b0;
               end else begin
                  pop_s = 1'b1;
               end
            end
            2'b11: begin
               // Replace on an empty stack degenerates to a push; empty
               // implies not full, so the push always lands.
               if (empty_s) begin
                  push_s = 1'b1;
               end else begin
                  repl_s = 1'b1;
               end
            end
            default: begin
               push_s = 1'b0;
               pop_s  = 1'b0;
               repl_s = 1'b0;
            end
         endcase
      end else begin
         push_s = 1'b0;
         pop_s  = 1'b0;
         repl_s = 1'b0;
      end
   end

   // PC, stack pointer and occupancy count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r  <= '0;
         sp_r  <= '0;
         cnt_r <= '0;
      end else if (pc_en) begin
         pc_r <= pc_next;
         if (push_s) begin
            sp_r  <= sp_r + PW'(1);
            cnt_r <= cnt_r + (PW+1)'(1);
         end else if (pop_s) begin
            sp_r  <= sp_r - PW'(1);
            cnt_r <= cnt_r - (PW+1)'(1);
         end
      end
   end

   // Stack storage; contents are unobservable while empty so it has no reset
   always_ff @(posedge clk) begin
      if (push_s) begin
         stack_r[sp_r] <= pc_inc_s;
      end else if (repl_s) begin
         stack_r[top_idx_s] <= pc_inc_s;
      end
   end

`ifdef PC_STACK_ERR_EN
   logic err_r;
   logic err_set_s;

   // A push while full or a pop while empty is misuse; replace never is
   always_comb begin
      err_set_s = pc_en & ((call & ~ret & full_s) | (~call & ret & empty_s));
   end

   // Sticky error flag, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_r <= 1'b0;
      end else if (err_set_s) begin
         err_r <= 1'b1;
      end
   end

   assign err = err_r;
`else
   assign err = 1'b0;
`endif

   assign pc       = pc_r;
   assign pc_inc   = pc_inc_s;
   assign ret_addr = empty_s ? '0 : stack_r[top_idx_s];
   assign full     = full_s;
   assign empty    = empty_s;

endmodule

// File: tb/tb_pc_stack.sv
// -----------------------------------------------------------------------------
// tb_pc_stack
// Directed test of pc_stack against a queue-based model of the return stack,
// with hand-computed literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_pc_stack;

   localparam int AW    = 13;
   localparam int DEPTH = 8;
`ifdef PC_STACK_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic          clk;
   logic          rst_n;
   logic          pc_en;
   logic [AW-1:0] pc_next;
   logic          call;
   logic          ret;
   logic [AW-1:0] pc;
   logic [AW-1:0] pc_inc;
   logic [AW-1:0] ret_addr;
   logic          full;
   logic          empty;
   logic          err;

   pc_stack #(.AW(AW), .DEPTH(DEPTH), .PW(3)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pc_en    (pc_en),
      .pc_next  (pc_next),
      .call     (call),
      .ret      (ret),
      .pc       (pc),
      .pc_inc   (pc_inc),
      .ret_addr (ret_addr),
      .full     (full),
      .empty    (empty),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: PC value, a LIFO of return addresses, sticky error flag
   logic [AW-1:0] m_pc;
   logic [AW-1:0] m_q [$];
   logic          m_err;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [AW-1:0] m_inc();
      logic [AW-1:0] v;
      v = m_pc + 13'd1;
      return v;
   endfunction

   function automatic logic [AW-1:0] m_top();
      if (m_q.size() == 0) return 13'd0;
      return m_q[m_q.size()-1];
   endfunction

   task automatic compare_all();
      cmp("pc",       {19'd0, pc},       {19'd0, m_pc});
      cmp("pc_inc",   {19'd0, pc_inc},   {19'd0, m_inc()});
      cmp("ret_addr", {19'd0, ret_addr}, {19'd0, m_top()});
      cmp("full",     {31'd0, full},     {31'd0, (m_q.size() == DEPTH)});
      cmp("empty",    {31'd0, empty},    {31'd0, (m_q.size() == 0)});
      cmp("err",      {31'd0, err},      {31'd0, m_err});
   endtask

   task automatic model_reset();
      m_pc  = 13'd0;
      m_q.delete();
      m_err = 1'b0;
   endtask

   // Apply the enabled command to the model as the rising edge would
   task automatic model_edge(input logic en, input logic c, input logic r, input logic [AW-1:0] nxt);
      logic [AW-1:0] inc;
      if (en) begin
         inc = m_inc();
         if (c && (!r || m_q.size() == 0)) begin
            if (m_q.size() < DEPTH) m_q.push_back(inc);
            else if (ERR_EN) m_err = 1'b1;
         end else if (c && r) begin
            m_q[m_q.size()-1] = inc;
         end else if (r) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
            else if (ERR_EN) m_err = 1'b1;
         end
         m_pc = nxt;
      end
   endtask

   // One clock cycle: drive inputs, model the edge, compare on falling edge
   task automatic step(input logic en, input logic c, input logic r, input logic [AW-1:0] nxt);
      pc_en = en; call = c; ret = r; pc_next = nxt;
      @(posedge clk);
      model_edge(en, c, r, nxt);
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      pc_en = 1'b0; call = 1'b0; ret = 1'b0; pc_next = 13'd0;
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      compare_all();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      pc_en = 1'b0; call = 1'b0; ret = 1'b0; pc_next = 13'd0;
      model_reset();
      repeat (2) @(negedge clk);
      compare_all();
      cmp("rst_pc_lit",     {19'd0, pc},       32'h0);
      cmp("rst_inc_lit",    {19'd0, pc_inc},   32'h1);
      cmp("rst_empty_lit",  {31'd0, empty},    32'h1);
      cmp("rst_ret_lit",    {19'd0, ret_addr}, 32'h0);
      rst_n = 1'b1;

      // Sequential advance
      for (int i = 1; i <= 3; i++) begin
         step(1'b1, 1'b0, 1'b0, m_inc());
         cmp("seq_pc_lit", {19'd0, pc}, i);
      end

      // Simple call / return
      step(1'b1, 1'b0, 1'b0, 13'h0005);
      step(1'b1, 1'b1, 1'b0, 13'h0100);
      cmp("call_ret_addr_lit", {19'd0, ret_addr}, 32'h0006);
      cmp("call_pc_lit",       {19'd0, pc},       32'h0100);
      step(1'b1, 1'b0, 1'b1, ret_addr);
      cmp("ret_pc_lit",        {19'd0, pc},       32'h0006);
      cmp("ret_empty_lit",     {31'd0, empty},    32'h1);

      // Eight nested calls from 0x10..0x80, then an overflowing ninth
      step(1'b1, 1'b0, 1'b0, 13'h0010);
      for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 1'b0, 13'((i + 1) * 16));
      cmp("nest_full_lit", {31'd0, full},     32'h1);
      cmp("nest_top_lit",  {19'd0, ret_addr}, 32'h0081);
      step(1'b1, 1'b1, 1'b0, 13'h0300);
      cmp("ovf_top_lit",   {19'd0, ret_addr}, 32'h0081);
      cmp("ovf_err_lit",   {31'd0, err},      {31'd0, ERR_EN});
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 1'b0, 1'b1, ret_addr);
         cmp("unwind_pc_lit", {19'd0, pc}, 32'h0081 - 32'(k * 16));
      end
      cmp("unwind_empty_lit", {31'd0, empty}, 32'h1);

      // Pop / call with pc_en low are ignored; enabled pop on empty is misuse
      do_reset();
      step(1'b1, 1'b0, 1'b0, 13'h0040);
      step(1'b0, 1'b0, 1'b1, 13'h0777);
      step(1'b0, 1'b1, 1'b0, 13'h0777);
      cmp("dis_pc_lit",  {19'd0, pc},    32'h0040);
      cmp("dis_err_lit", {31'd0, err},   32'h0);
      step(1'b1, 1'b0, 1'b1, 13'h0041);
      cmp("udf_empty_lit", {31'd0, empty},    32'h1);
      cmp("udf_ret_lit",   {19'd0, ret_addr}, 32'h0);
      cmp("udf_err_lit",   {31'd0, err},      {31'd0, ERR_EN});

      // Replace: one entry 0x0031, call+ret at 0x0200
      do_reset();
      step(1'b1, 1'b0, 1'b0, 13'h0030);
      step(1'b1, 1'b1, 1'b0, 13'h0200);
      cmp("repl_pre_lit", {19'd0, ret_addr}, 32'h0031);
      step(1'b1, 1'b1, 1'b1, 13'h0400);
      cmp("repl_top_lit", {19'd0, ret_addr}, 32'h0201);
      step(1'b1, 1'b0, 1'b1, ret_addr);
      cmp("repl_cnt1_lit", {31'd0, empty}, 32'h1);
      // Replace on empty acts as push
      step(1'b1, 1'b1, 1'b1, 13'h0500);
      cmp("repl_empty_lit", {19'd0, ret_addr}, 32'h0202);

      // Replace on a full stack is not misuse; overflowing push is
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 13'(32'h0600 + i * 2));
      step(1'b1, 1'b1, 1'b1, 13'h0700);
      cmp("repl_full_err_lit", {31'd0, err},      32'h0);
      cmp("repl_full_top_lit", {19'd0, ret_addr}, 32'h060F);
      step(1'b1, 1'b1, 1'b0, 13'h0701);

      // PC wrap
      step(1'b1, 1'b0, 1'b0, 13'h1FFF);
      cmp("wrap_inc_lit", {19'd0, pc_inc}, 32'h0);

      // Asynchronous reset between edges during a push burst
      do_reset();
      step(1'b1, 1'b1, 1'b0, 13'h0100);
      step(1'b1, 1'b1, 1'b0, 13'h0200);
      pc_en = 1'b1; call = 1'b1; ret = 1'b0; pc_next = 13'h0300;
      @(posedge clk);
      model_edge(1'b1, 1'b1, 1'b0, 13'h0300);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      cmp("arst_pc_lit",    {19'd0, pc},    32'h0);
      cmp("arst_empty_lit", {31'd0, empty}, 32'h1);
      cmp("arst_err_lit",   {31'd0, err},   32'h0);
      @(negedge clk);
      compare_all();
      pc_en = 1'b0; call = 1'b0;
      rst_n = 1'b1;
      step(1'b1, 1'b1, 1'b0, 13'h1FFF);
      step(1'b1, 1'b1, 1'b0, 13'h0010);
      cmp("push_wrap_lit", {19'd0, ret_addr}, 32'h0);
      cmp("push_wrap_nonempty_lit", {31'd0, empty}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
